// File: rtl/lc3_pkg.sv
// Shared LC-3 fetch definitions: word width, reset PC, fetch FSM states
// and the PC increment helper.
package lc3_pkg;

    localparam int WORD_W = 16;

    localparam logic [WORD_W-1:0] LC3_PC_RESET = 16'h0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } fetch_state_t;

    // Sequential PC step. The 16-bit result wraps from 16'hFFFF to 16'h0000.
    function automatic logic [WORD_W-1:0] pc_inc(input logic [WORD_W-1:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/lc3_fetch_if.sv
// Fetch-stage bus: instruction memory read handshake plus the IR
// valid/ack handshake towards decode.
interface lc3_fetch_if;

    logic                         Mem_Req;
    logic [lc3_pkg::WORD_W-1:0]   Mem_Addr;
    logic                         Mem_Rdy;
    logic [lc3_pkg::WORD_W-1:0]   Mem_Data;
    logic [lc3_pkg::WORD_W-1:0]   IR;
    logic                         IR_Valid;
    logic                         IR_Ack;

    // Fetch stage side.
    modport master (
        output Mem_Req,
        output Mem_Addr,
        input  Mem_Rdy,
        input  Mem_Data,
        output IR,
        output IR_Valid,
        input  IR_Ack
    );

    // Memory / decode side.
    modport slave (
        input  Mem_Req,
        input  Mem_Addr,
        output Mem_Rdy,
        output Mem_Data,
        input  IR,
        input  IR_Valid,
        output IR_Ack
    );

endinterface

// File: rtl/lc3_fetch_reg_16.sv
// 16-bit register with load enable and synchronous active-low reset.
// Used for the PC, MAR and IR of the fetch stage.
module reg_16 #(
    parameter logic [15:0] RST_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld,
    input  logic [15:0] d,
    output logic [15:0] q
);

    // Reset wins over load; otherwise hold unless loaded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/lc3_fetch.sv
// LC-3 instruction fetch stage. Keeps PC and MAR, issues reads to
// instruction memory, captures the returned word into IR and hands it
// to decode. A redirect replaces the PC; a redirect that arrives while a
// read is outstanding lets that read finish and throws its data away.
module lc3_fetch
    import lc3_pkg::*;
#(
    parameter logic [WORD_W-1:0] PC_RESET = LC3_PC_RESET
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Run,
    input  logic               Redirect,
    input  logic [WORD_W-1:0]  Redirect_PC,
    output logic [WORD_W-1:0]  PC,
    lc3_fetch_if.master        bus
);

    localparam logic [1:0] ST_IDLE  = S_IDLE;
    localparam logic [1:0] ST_REQ   = S_REQ;
    localparam logic [1:0] ST_DRAIN = S_DRAIN;
    localparam logic [1:0] ST_HOLD  = S_HOLD;

    logic [1:0]        state_q;
    logic [1:0]        state_d;

    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] pc_d;
    logic              pc_ld;

    logic [WORD_W-1:0] mar_q;
    logic [WORD_W-1:0] mar_d;
    logic              mar_ld;

    logic [WORD_W-1:0] ir_q;
    logic [WORD_W-1:0] ir_d;
    logic              ir_ld;

    reg_16 #(.RST_VAL(PC_RESET)) u_pc (
        .clk   (Clk),
        .rst_n (Reset),
        .ld    (pc_ld),
        .d     (pc_d),
        .q     (pc_q)
    );

    reg_16 #(.RST_VAL(16'h0000)) u_mar (
        .clk   (Clk),
        .rst_n (Reset),
        .ld    (mar_ld),
        .d     (mar_d),
        .q     (mar_q)
    );

    reg_16 #(.RST_VAL(16'h0000)) u_ir (
        .clk   (Clk),
        .rst_n (Reset),
        .ld    (ir_ld),
        .d     (ir_d),
        .q     (ir_q)
    );

    // Next-state, PC/MAR/IR load decisions for the fetch handshake.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pc_ld   = 1'b0;
        mar_d   = mar_q;
        mar_ld  = 1'b0;
        ir_d    = bus.Mem_Data;
        ir_ld   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Redirect) begin
                    pc_d  = Redirect_PC;
                    pc_ld = 1'b1;
                end
                if (Run) begin
                    // A same-cycle redirect must already steer the first read.
                    mar_d   = Redirect ? Redirect_PC : pc_q;
                    mar_ld  = 1'b1;
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                if (Redirect) begin
                    pc_d  = Redirect_PC;
                    pc_ld = 1'b1;
                    if (bus.Mem_Rdy) begin
                        // Read just completed: drop it and start at the target.
                        mar_d  = Redirect_PC;
                        mar_ld = 1'b1;
                    end else begin
                        // Keep MAR so the outstanding request stays stable.
                        state_d = ST_DRAIN;
                    end
                end else if (bus.Mem_Rdy) begin
                    ir_ld   = 1'b1;
                    pc_d    = pc_inc(pc_q);
                    pc_ld   = 1'b1;
                    state_d = ST_HOLD;
                end
            end

            ST_DRAIN: begin
                if (Redirect) begin
                    pc_d  = Redirect_PC;
                    pc_ld = 1'b1;
                end
                if (bus.Mem_Rdy) begin
                    // Squashed read finished; refetch from the latest target.
                    mar_d   = Redirect ? Redirect_PC : pc_q;
                    mar_ld  = 1'b1;
                    state_d = ST_REQ;
                end
            end

            ST_HOLD: begin
                if (Redirect) begin
                    pc_d    = Redirect_PC;
                    pc_ld   = 1'b1;
                    mar_d   = Redirect_PC;
                    mar_ld  = 1'b1;
                    state_d = Run ? ST_REQ : ST_IDLE;
                end else if (bus.IR_Ack) begin
                    mar_d   = pc_q;
                    mar_ld  = 1'b1;
                    state_d = Run ? ST_REQ : ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register; reset abandons any outstanding request.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore outputs decoded straight from the state register.
    always_comb begin
        bus.Mem_Req  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
        bus.IR_Valid = (state_q == ST_HOLD);
        bus.Mem_Addr = mar_q;
        bus.IR       = ir_q;
        PC           = pc_q;
    end

endmodule
